muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit with FSM sequencing, one bit per cycle. Replaces the single-cycle

---
 rtl/muldiv_sequencer_if.sv | 15 +
 rtl/muldiv_sequencer.sv | 112 +++++++++++
 tb/tb_muldiv_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Core <-> iterative mul/div unit handshake: request (start/op/a/b) and
// registered response (busy/done/result/div_by_zero).
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (output start, op, a, b, input busy, done, result, div_by_zero);
  modport slave  (input start, op, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to let MUL finish once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MUL = 2'd0, OP_DIVU = 2'd1, OP_REMU = 2'd2, OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]        count;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc, opnd;
  logic [WIDTH-1:0]     mplr, rem;

  logic                 accept, fast, b_zero, last;
  logic [WIDTH-1:0]     a_mag, b_mag, res_fast, res_step, mplr_step;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       shifted, trial, rem_step;

  // Request decode: only looks at inputs when a start can be accepted.
  always_comb begin
    accept = bus.start && (state != RUN);
    b_zero = (bus.b == '0);
`ifdef MULDIV_EARLY_OUT_EN
    fast   = b_zero;
`else
    fast   = b_zero && (bus.op != OP_MUL);
`endif
    a_mag  = (bus.op == OP_DIV && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag  = (bus.op == OP_DIV && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    case (bus.op)
      OP_MUL:  res_fast = '0;
      OP_REMU: res_fast = bus.a;
      default: res_fast = '1;
    endcase
  end

  // One iteration: mplr is the multiplier for MUL and the dividend/quotient
  // shift register for divides; rem is the partial remainder.
  always_comb begin
    acc_step  = mplr[0] ? acc + opnd : acc;
    shifted   = {rem, mplr[WIDTH-1]};
    trial     = shifted - {1'b0, opnd[WIDTH-1:0]};
    rem_step  = trial[WIDTH] ? shifted : trial;
    mplr_step = (op_q == OP_MUL) ? (mplr >> 1) : {mplr[WIDTH-2:0], ~trial[WIDTH]};
    last      = (count == CW'(1));
`ifdef MULDIV_EARLY_OUT_EN
    if (op_q == OP_MUL && mplr_step == '0) last = 1'b1;
`endif
    case (op_q)
      OP_MUL:  res_step = acc_step[WIDTH-1:0];
      OP_DIVU: res_step = mplr_step;
      OP_REMU: res_step = rem_step[WIDTH-1:0];
      default: res_step = neg_q ? -mplr_step : mplr_step;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = bus.start ? (fast ? DONE : RUN) : IDLE;
      RUN:        if (last) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result      <= '0;
      bus.div_by_zero <= 1'b0;
      count           <= '0;
      op_q            <= OP_MUL;
      neg_q           <= 1'b0;
      acc             <= '0;
      opnd            <= '0;
      mplr            <= '0;
      rem             <= '0;
    end else begin
      state    <= state_nx;
      bus.busy <= (state_nx == RUN);
      bus.done <= (state_nx == DONE);
      if (accept) begin
        op_q            <= bus.op;
        neg_q           <= (bus.op == OP_DIV) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        count           <= CW'(WIDTH);
        acc             <= '0;
        opnd            <= {{WIDTH{1'b0}}, (bus.op == OP_MUL) ? bus.a : b_mag};
        mplr            <= (bus.op == OP_MUL) ? bus.b : a_mag;
        rem             <= '0;
        bus.div_by_zero <= b_zero && (bus.op != OP_MUL);
        if (fast) bus.result <= res_fast;
      end else if (state == RUN) begin
        count <= count - CW'(1);
        acc   <= acc_step;
        opnd  <= (op_q == OP_MUL) ? (opnd << 1) : opnd;
        mplr  <= mplr_step;
        rem   <= rem_step[WIDTH-1:0];
        if (last) bus.result <= res_step;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector table plus hand-written multi-cycle sequences for muldiv_sequencer.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [1:0] MUL = 2'd0, DIVU = 2'd1, REMU = 2'd2, DIV = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         dbz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected MUL latency (negedges from accept to done inclusive).
  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    for (int i = W - 1; i >= 0; i--)
      if (b[i]) return i + 2;
    return 1;
`else
    return W + 1;
`endif
  endfunction

  // Drive a request at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int busy_n, output logic ov);
    lat = lat0; busy_n = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    ov = bus.busy & bus.done;
  endtask

  vec_t v[15];

  initial begin
    int lat, bn, elat;
    logic ov;
    v[0]  = '{MUL,  32'd7,         32'd6,         32'd42,         1'b0, 33};
    v[1]  = '{DIVU, 32'd100,       32'd7,         32'd14,         1'b0, 33};
    v[2]  = '{REMU, 32'd100,       32'd7,         32'd2,          1'b0, 33};
    v[3]  = '{DIV,  32'hFFFFFFEC,  32'd3,         32'hFFFFFFFA,   1'b0, 33};
    v[4]  = '{DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,   1'b0, 33};
    v[5]  = '{DIVU, 32'd5,         32'd0,         32'hFFFFFFFF,   1'b1, 1};
    v[6]  = '{REMU, 32'd5,         32'd0,         32'd5,          1'b1, 1};
    v[7]  = '{DIV,  32'd5,         32'd0,         32'hFFFFFFFF,   1'b1, 1};
    v[8]  = '{MUL,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,          1'b0, 33};
    v[9]  = '{MUL,  32'h12345678,  32'h10,        32'h23456780,   1'b0, 33};
    v[10] = '{DIV,  32'd20,        32'hFFFFFFFD,  32'hFFFFFFFA,   1'b0, 33};
    v[11] = '{DIVU, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,   1'b0, 33};
    v[12] = '{REMU, 32'hFFFFFFFF,  32'd10,        32'd5,          1'b0, 33};
    v[13] = '{MUL,  32'd5,         32'd2,         32'd10,         1'b0, 33};
    v[14] = '{MUL,  32'd9,         32'd0,         32'd0,          1'b0, 33};

    bus.start = 1'b0; bus.op = MUL; bus.a = '0; bus.b = '0;
    #1 reset = 1'b1;
    #1;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset result", bus.result, 0);
    check("reset dbz", bus.div_by_zero, 0);
    @(negedge clk); reset = 1'b0;

    foreach (v[i]) begin
      elat = (v[i].op == MUL) ? mul_lat(v[i].b) : v[i].lat;
      @(negedge clk);
      issue(v[i].op, v[i].a, v[i].b);
      wait_done(1, lat, bn, ov);
      check($sformatf("v%0d result", i), bus.result, v[i].res);
      check($sformatf("v%0d dbz", i), bus.div_by_zero, v[i].dbz);
      check($sformatf("v%0d latency", i), lat, elat);
      check($sformatf("v%0d busy cycles", i), bn, elat - 1);
      check($sformatf("v%0d busy&done", i), ov, 0);
    end

    // done is a single-cycle pulse and result holds afterwards
    @(negedge clk);
    check("done pulse width", bus.done, 0);
    check("result hold", bus.result, 0);

    // start during RUN is ignored
    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = MUL; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    check("midrun busy", bus.busy, 1);
    wait_done(6, lat, bn, ov);
    check("midrun result", bus.result, 32'd14);
    check("midrun latency", lat, 33);

    // back-to-back: start on the done cycle
    @(negedge clk);
    issue(DIVU, 32'd100, 32'd7);
    wait_done(1, lat, bn, ov);
    check("b2b first result", bus.result, 32'd14);
    issue(REMU, 32'd100, 32'd7);
    check("b2b done dropped", bus.done, 0);
    check("b2b busy", bus.busy, 1);
    wait_done(1, lat, bn, ov);
    check("b2b second result", bus.result, 32'd2);
    check("b2b second latency", lat, 33);
    issue(DIVU, 32'd5, 32'd0);
    wait_done(1, lat, bn, ov);
    check("b2b dbz latency", lat, 1);
    check("b2b dbz flag", bus.div_by_zero, 1);
    issue(MUL, 32'd3, 32'd3);
    check("dbz cleared on start", bus.div_by_zero, 0);
    wait_done(1, lat, bn, ov);
    check("b2b mul result", bus.result, 32'd9);

    // async reset in the middle of RUN
    @(negedge clk);
    issue(MUL, 32'hFF, 32'hFF);
    repeat (9) @(negedge clk);
    check("pre-reset busy", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midreset busy", bus.busy, 0);
    check("midreset done", bus.done, 0);
    check("midreset result", bus.result, 0);
    check("midreset dbz", bus.div_by_zero, 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("post-reset idle done", bus.done, 0);
    issue(MUL, 32'd3, 32'd3);
    wait_done(1, lat, bn, ov);
    check("post-reset result", bus.result, 32'd9);
    check("post-reset latency", lat, mul_lat(32'd3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
